bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Shares one bram_align1_2048 instance (2048 x 32 words) between NPORTS requesters, for example instruction fetch and the load/store unit.
- Arbitration is round-robin.
- Each requester gets a valid/ready request channel and a response channel.
- Byte-masked writes are performed as read-modify-write, because the BRAM only supports full-word writes. The block sits directly in front of the BRAM port.

Parameters:
- NPORTS, 2, number of requesters (2..4).
- ADDR_W, 11, word address width; must match the BRAM.
- DATA_W, 32, data width; byte mask width is DATA_W/8.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NPORTS  request present, per port.
- req_ready  out  NPORTS  request accepted this cycle.
- req_addr  in  NPORTS x ADDR_W  word address.
- req_write  in  NPORTS  1 = write, 0 = read.
- req_wdata  in  NPORTS x DATA_W  write data.
- req_mask  in  NPORTS x DATA_W/8  byte enables; ignored for reads.
- rsp_valid  out  NPORTS  response pulse, per port.
- rsp_data  out  DATA_W  read data; shared bus, qualified by rsp_valid.
- bram_raddr  out  ADDR_W  to BRAM raddr.
- bram_waddr  out  ADDR_W  to BRAM waddr.
- bram_wdata  out  DATA_W  to BRAM wdata.
- bram_wren  out  1  to BRAM wren.
- bram_out  in  DATA_W  from BRAM out; valid the cycle after raddr is presented.

Behaviour:
- Reset values:
  - state = ISSUE; rr pointer = NPORTS-1, so port 0 wins the first arbitration.
  - rsp_valid = 0, rsp_data = 0.
  - bram_wren = 0, bram_raddr = 0, bram_waddr = 0, bram_wdata = 0.
- Arbitration:
  - Grant goes to the first valid port after the rr pointer.
  - req_ready[g] = 1 only in state ISSUE, combinationally from req_valid. At most one ready bit is high per cycle.
  - On accept, the rr pointer becomes g.
  - Requesters must hold valid/addr/data stable until ready; valid must not depend on ready.
- ISSUE state, accept at cycle t:
  - Read: bram_raddr = addr at t; rsp_valid[g] = 1 and rsp_data = bram_out at t+1. Back-to-back reads sustain 1 per cycle.
  - Write with mask all-ones: bram_waddr/wdata = request and bram_wren = 1 at t. Ack rsp_valid[g] at t+1 with rsp_data = 0.
  - Write with mask = 0: no BRAM write; ack at t+1.
  - Write with partial mask: bram_raddr = addr at t; go to MERGE. Latch port, addr, wdata, mask.
- MERGE state (cycle t+1):
  - req_ready = 0 for all ports.
  - bram_wdata byte k = mask[k] ? wdata byte k : bram_out byte k; bram_wren = 1; bram_waddr = latched addr.
  - Return to ISSUE; ack rsp_valid[g] at t+2.
- Hazards:
  - Only one op is issued per cycle, and reads stall during MERGE, so no same-cycle read/write collision exists.
  - A read issued the cycle after a write returns the new data.
- No valid requests: bram_wren = 0, outputs hold, rr pointer unchanged.
- Reset asserted in MERGE: the pending write is dropped (bram_wren = 0 next cycle) and no ack is issued.
- rsp_valid is always a single-cycle pulse to exactly the issuing port.

Optional Feature:
- Macro: BRAM_ARBITER_STATS_EN.
- Defined: adds output grant_count (NPORTS x 32) and output stall_count (32), both cleared on reset and wrapping at 2^32.
  - grant_count[i] increments on each accept by port i.
  - stall_count increments each cycle in which any req_valid is high with its req_ready low.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bram_arbiter_pkg:
  - ADDR_W/DATA_W defaults.
  - state enum {ISSUE, MERGE}.
  - packed struct req_t {addr, write, wdata, mask}.
  - function merge_bytes(old, new, mask).
- One sub-module: rr_arbiter (NPORTS request in, one-hot grant out, pointer update on accept enable).

Test Plan:
- Port 0 full write 0x12345678 to addr 0x011, then port 0 read of 0x011 -> wren at accept cycle, ack next cycle; read rsp_data = 0x12345678 exactly one cycle after accept.
- Both ports continuously valid with reads -> grants alternate 0,1,0,1 starting with port 0; each rsp_valid goes only to the issuer.
- Word 0x020 = 0xAABBCCDD, then port 1 write 0x11223344 with mask 4'b0101 -> no ready for either port in the MERGE cycle; ack at t+2; read back 0xAA22CC44.
- Write with mask 0 to addr 0x030 holding 0xDEADBEEF -> bram_wren stays 0; ack at t+1; read back 0xDEADBEEF.
- Partial write accepted, then reset asserted during MERGE -> bram_wren = 0, no ack, memory word unchanged, port 0 wins the first grant after reset.
- With BRAM_ARBITER_STATS_EN: 10 contended cycles of two readers -> grant_count = {5,5}, stall_count = 10.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// Shared types and helpers for the round-robin BRAM arbiter.
package bram_arbiter_pkg;

    localparam int unsigned BRAM_ADDR_W = 11;
    localparam int unsigned BRAM_DATA_W = 32;
    localparam int unsigned BRAM_MASK_W = BRAM_DATA_W / 8;

    typedef enum logic {
        ISSUE,
        MERGE
    } state_t;

    typedef struct packed {
        logic [BRAM_ADDR_W-1:0] addr;
        logic                   write;
        logic [BRAM_DATA_W-1:0] wdata;
        logic [BRAM_MASK_W-1:0] mask;
    } req_t;

    // Byte k comes from new_word where mask[k] is set, otherwise from old_word.
    function automatic logic [BRAM_DATA_W-1:0] merge_bytes(
        input logic [BRAM_DATA_W-1:0] old_word,
        input logic [BRAM_DATA_W-1:0] new_word,
        input logic [BRAM_MASK_W-1:0] mask
    );
        logic [BRAM_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(BRAM_MASK_W); k++) begin
            if (mask[k]) res[k*8 +: 8] = new_word[k*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the pointer.
module rr_arbiter #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              accept,
    output logic [NPORTS-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= int'(NPORTS); i++) begin
            cand = IDX_W'((int'(ptr) + i) % int'(NPORTS));
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // Pointer starts at the last port so port 0 wins first after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= IDX_W'(NPORTS - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one 2048x32 BRAM port among NPORTS requesters; partial writes use read-modify-write.
// Optional BRAM_ARBITER_STATS_EN adds grant_count / stall_count outputs.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned ADDR_W = BRAM_ADDR_W,
    parameter int unsigned DATA_W = BRAM_DATA_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NPORTS-1:0]              req_valid,
    output logic [NPORTS-1:0]              req_ready,
    input  logic [NPORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NPORTS-1:0]              req_write,
    input  logic [NPORTS-1:0][DATA_W-1:0]  req_wdata,
    input  logic [NPORTS-1:0][DATA_W/8-1:0] req_mask,
    output logic [NPORTS-1:0]              rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
`ifdef BRAM_ARBITER_STATS_EN
    output logic [NPORTS-1:0][31:0]        grant_count,
    output logic [31:0]                    stall_count,
`endif
    output logic [ADDR_W-1:0]              bram_raddr,
    output logic [ADDR_W-1:0]              bram_waddr,
    output logic [DATA_W-1:0]              bram_wdata,
    output logic                           bram_wren,
    input  logic [DATA_W-1:0]              bram_out
);

    localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    state_t              state_q, state_n;
    req_t                pend_q, pend_n, greq;
    logic [NPORTS-1:0]   pgrant_q, pgrant_n;
    logic [NPORTS-1:0]   arb_req, grant, rsp_n;
    logic [IDX_W-1:0]    gidx;
    logic                accept, rsp_rd_q, rsp_rd_n;
    logic [ADDR_W-1:0]   raddr_q, raddr_n, waddr_q, waddr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic                wren_n;

    assign arb_req   = (state_q == ISSUE && !reset) ? req_valid : '0;
    assign accept    = |grant;
    assign req_ready = grant;

    rr_arbiter #(.NPORTS(NPORTS), .IDX_W(IDX_W)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (arb_req),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (gidx)
    );

    always_comb begin
        greq.addr  = req_addr[gidx];
        greq.write = req_write[gidx];
        greq.wdata = req_wdata[gidx];
        greq.mask  = req_mask[gidx];
    end

    // Next-state and BRAM drive; idle cycles keep the last addresses/data.
    always_comb begin
        state_n  = state_q;
        pend_n   = pend_q;
        pgrant_n = pgrant_q;
        raddr_n  = raddr_q;
        waddr_n  = waddr_q;
        wdata_n  = wdata_q;
        wren_n   = 1'b0;
        rsp_n    = '0;
        rsp_rd_n = 1'b0;
        case (state_q)
            ISSUE: begin
                if (accept) begin
                    if (!greq.write) begin
                        raddr_n  = greq.addr;
                        rsp_n    = grant;
                        rsp_rd_n = 1'b1;
                    end else if (greq.mask == '1) begin
                        waddr_n = greq.addr;
                        wdata_n = greq.wdata;
                        wren_n  = 1'b1;
                        rsp_n   = grant;
                    end else if (greq.mask == '0) begin
                        rsp_n = grant;
                    end else begin
                        raddr_n  = greq.addr;
                        pend_n   = greq;
                        pgrant_n = grant;
                        state_n  = MERGE;
                    end
                end
            end
            MERGE: begin
                waddr_n = pend_q.addr;
                wdata_n = merge_bytes(bram_out, pend_q.wdata, pend_q.mask);
                wren_n  = !reset;
                rsp_n   = pgrant_q;
                state_n = ISSUE;
            end
            default: state_n = ISSUE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ISSUE;
            pend_q    <= '0;
            pgrant_q  <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rsp_valid <= '0;
            rsp_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            pend_q    <= pend_n;
            pgrant_q  <= pgrant_n;
            raddr_q   <= raddr_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            rsp_valid <= rsp_n;
            rsp_rd_q  <= rsp_rd_n;
        end
    end

    assign bram_raddr = raddr_n;
    assign bram_waddr = waddr_n;
    assign bram_wdata = wdata_n;
    assign bram_wren  = wren_n;
    assign rsp_data   = rsp_rd_q ? bram_out : '0;

`ifdef BRAM_ARBITER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_count <= '0;
            stall_count <= '0;
        end else begin
            for (int i = 0; i < int'(NPORTS); i++) begin
                if (grant[i]) grant_count[i] <= grant_count[i] + 32'd1;
            end
            if (|(req_valid & ~req_ready)) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 2048x32 BRAM model.
module tb_bram_arbiter;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req_valid, req_ready, req_write, rsp_valid;
    logic [1:0][10:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_mask;
    logic [31:0]       rsp_data, bram_wdata, bram_out;
    logic [10:0]       bram_raddr, bram_waddr;
    logic              bram_wren;
`ifdef BRAM_ARBITER_STATS_EN
    logic [1:0][31:0]  grant_count;
    logic [31:0]       stall_count;
`endif

    logic [31:0] mem [2048];
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bram_wren) mem[bram_waddr] <= bram_wdata;
        bram_out <= mem[bram_raddr];
    end

    bram_arbiter #(.NPORTS(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef BRAM_ARBITER_STATS_EN
        .grant_count(grant_count), .stall_count(stall_count),
`endif
        .bram_raddr(bram_raddr), .bram_waddr(bram_waddr),
        .bram_wdata(bram_wdata), .bram_wren(bram_wren), .bram_out(bram_out)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  wr;
        logic [10:0] a0;
        logic [10:0] a1;
        logic [31:0] wd;
        logic [3:0]  mk;
        logic [1:0]  rdy;
        logic        wren;
        logic [31:0] wdat;
        logic [1:0]  rspv;
        logic [31:0] rspd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] wr, input logic [10:0] a0,
                         input logic [10:0] a1, input logic [31:0] wd, input logic [3:0] mk);
        req_valid    = v;
        req_write    = wr;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = wd;
        req_wdata[1] = wd;
        req_mask[0]  = mk;
        req_mask[1]  = mk;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h020] = 32'hAABBCCDD;
        mem[11'h030] = 32'hDEADBEEF;
        mem[11'h040] = 32'h55667788;

        // Contended reads, full write + readback, partial write, zero-mask write.
        vecs[0]  = '{2'b11, 2'b00, 11'h020, 11'h030, 32'h0,        4'h0, 2'b01, 1'b0, 32'h0,        2'b00, 32'h0};
        vecs[1]  = '{2'b11, 2'b00, 11'h020, 11'h030, 32'h0,        4'h0, 2'b10, 1'b0, 32'h0,        2'b01, 32'hAABBCCDD};
        vecs[2]  = '{2'b11, 2'b00, 11'h020, 11'h030, 32'h0,        4'h0, 2'b01, 1'b0, 32'h0,        2'b10, 32'hDEADBEEF};
        vecs[3]  = '{2'b11, 2'b00, 11'h020, 11'h030, 32'h0,        4'h0, 2'b10, 1'b0, 32'h0,        2'b01, 32'hAABBCCDD};
        vecs[4]  = '{2'b00, 2'b00, 11'h000, 11'h000, 32'h0,        4'h0, 2'b00, 1'b0, 32'h0,        2'b10, 32'hDEADBEEF};
        vecs[5]  = '{2'b00, 2'b00, 11'h000, 11'h000, 32'h0,        4'h0, 2'b00, 1'b0, 32'h0,        2'b00, 32'h0};
        vecs[6]  = '{2'b01, 2'b01, 11'h011, 11'h000, 32'h12345678, 4'hF, 2'b01, 1'b1, 32'h12345678, 2'b00, 32'h0};
        vecs[7]  = '{2'b01, 2'b00, 11'h011, 11'h000, 32'h0,        4'h0, 2'b01, 1'b0, 32'h0,        2'b01, 32'h0};
        vecs[8]  = '{2'b00, 2'b00, 11'h000, 11'h000, 32'h0,        4'h0, 2'b00, 1'b0, 32'h0,        2'b01, 32'h12345678};
        vecs[9]  = '{2'b10, 2'b10, 11'h000, 11'h020, 32'h11223344, 4'h5, 2'b10, 1'b0, 32'h0,        2'b00, 32'h0};
        vecs[10] = '{2'b01, 2'b00, 11'h020, 11'h000, 32'h0,        4'h0, 2'b00, 1'b1, 32'hAA22CC44, 2'b00, 32'h0};
        vecs[11] = '{2'b01, 2'b00, 11'h020, 11'h000, 32'h0,        4'h0, 2'b01, 1'b0, 32'h0,        2'b10, 32'h0};
        vecs[12] = '{2'b00, 2'b00, 11'h000, 11'h000, 32'h0,        4'h0, 2'b00, 1'b0, 32'h0,        2'b01, 32'hAA22CC44};
        vecs[13] = '{2'b01, 2'b01, 11'h030, 11'h000, 32'hFFFFFFFF, 4'h0, 2'b01, 1'b0, 32'h0,        2'b00, 32'h0};
        vecs[14] = '{2'b01, 2'b00, 11'h030, 11'h000, 32'h0,        4'h0, 2'b01, 1'b0, 32'h0,        2'b01, 32'h0};
        vecs[15] = '{2'b00, 2'b00, 11'h000, 11'h000, 32'h0,        4'h0, 2'b00, 1'b0, 32'h0,        2'b01, 32'hDEADBEEF};

        reset = 1'b1;
        drive(2'b00, 2'b00, 11'h0, 11'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data", rsp_data, 32'h0);
        check("reset bram_wren", 32'(bram_wren), 32'h0);
        check("reset bram_raddr", 32'(bram_raddr), 32'h0);
        check("reset bram_waddr", 32'(bram_waddr), 32'h0);
        check("reset bram_wdata", bram_wdata, 32'h0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].wr, vecs[i].a0, vecs[i].a1, vecs[i].wd, vecs[i].mk);
            @(negedge clock);
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d bram_wren", i), 32'(bram_wren), 32'(vecs[i].wren));
            if (vecs[i].wren) check($sformatf("vec%0d bram_wdata", i), bram_wdata, vecs[i].wdat);
            check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rspv));
            if (vecs[i].rspv != 2'b00) check($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].rspd);
            next_cycle();
        end

        // Reset during MERGE drops the pending partial write.
        drive(2'b01, 2'b01, 11'h040, 11'h000, 32'hFFFFFFFF, 4'h3);
        @(negedge clock);
        check("rstmerge accept ready", 32'(req_ready), 32'h1);
        next_cycle();
        drive(2'b00, 2'b00, 11'h0, 11'h0, 32'h0, 4'h0);
        reset = 1'b1;
        @(negedge clock);
        check("rstmerge wren in merge", 32'(bram_wren), 32'h0);
        check("rstmerge rsp_valid", 32'(rsp_valid), 32'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("rstmerge wren after", 32'(bram_wren), 32'h0);
        check("rstmerge no ack", 32'(rsp_valid), 32'h0);
        check("rstmerge mem unchanged", mem[11'h040], 32'h55667788);
        next_cycle();
        drive(2'b11, 2'b00, 11'h040, 11'h020, 32'h0, 4'h0);
        @(negedge clock);
        check("post-reset first grant", 32'(req_ready), 32'h1);
        next_cycle();
        drive(2'b10, 2'b00, 11'h040, 11'h020, 32'h0, 4'h0);
        @(negedge clock);
        check("post-reset second grant", 32'(req_ready), 32'h2);
        check("post-reset rsp_valid p0", 32'(rsp_valid), 32'h1);
        check("post-reset rsp_data p0", rsp_data, 32'h55667788);
        next_cycle();
        drive(2'b00, 2'b00, 11'h0, 11'h0, 32'h0, 4'h0);
        @(negedge clock);
        check("post-reset rsp_valid p1", 32'(rsp_valid), 32'h2);
        check("post-reset rsp_data p1", rsp_data, 32'hAA22CC44);
        next_cycle();

`ifdef BRAM_ARBITER_STATS_EN
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(2'b11, 2'b00, 11'h020, 11'h030, 32'h0, 4'h0);
        repeat (10) next_cycle();
        drive(2'b00, 2'b00, 11'h0, 11'h0, 32'h0, 4'h0);
        @(negedge clock);
        check("grant_count[0]", grant_count[0], 32'd5);
        check("grant_count[1]", grant_count[1], 32'd5);
        check("stall_count", stall_count, 32'd10);
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
